// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: digit scan scheduler for an 8-digit seven-segment display.
// Steps one digit per SCAN_DIV-cycle slot and hands that digit's nibble to the hex decoder.
// Display words are double-buffered and take effect only at a frame boundary.
// Per-digit blanking, PWM dimming and anti-ghost darkening are applied to the an outputs.
// Optional feature: define LEADING_ZERO_SUPPRESS_EN to darken leading zero digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DIM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [DIM_BITS-1:0]     duty,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [3:0]              digit_data,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t                state_r;
    buf_state_t                state_s;
    logic [PW-1:0]             pcnt_r;
    logic [2:0]                idx_r;
    logic [DIM_BITS-1:0]       phase_r;
    logic [4*NUM_DIGITS-1:0]   active_r;
    logic [4*NUM_DIGITS-1:0]   shadow_r;
    logic [NUM_DIGITS-1:0]     supp_s;
    logic [NUM_DIGITS-1:0]     an_s;
    logic                      tick_s;
    logic                      boundary_s;
    logic                      accept_s;
    logic                      swap_s;
    logic                      lit_s;

    assign tick_s     = (pcnt_r == PW'(SCAN_DIV - 1));
    assign boundary_s = tick_s && (idx_r == 3'(NUM_DIGITS - 1));
    assign accept_s   = load_valid && (state_r == EMPTY);
    assign swap_s     = boundary_s && (state_r == FULL);
    assign lit_s      = (phase_r <= duty);

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] supp_r;

    // Marks zero digits above the highest non-zero digit; digit 0 is always shown.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (!seen && (d[4*i +: 4] == 4'h0)) begin
                m[i] = 1'b1;
            end else begin
                seen = 1'b1;
            end
        end
        return m;
    endfunction

    // Suppression mask tracks the active buffer, refreshed whenever it is replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            supp_r <= lz_mask('0);
        end else if (swap_s) begin
            supp_r <= lz_mask(shadow_r);
        end else begin
            supp_r <= supp_r;
        end
    end

    assign supp_s = supp_r;
`else
    assign supp_s = '0;
`endif

    // Slot prescaler, digit index and PWM phase counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r  <= '0;
            idx_r   <= 3'd0;
            phase_r <= '0;
        end else begin
            pcnt_r  <= tick_s ? '0 : pcnt_r + PW'(1);
            phase_r <= phase_r + DIM_BITS'(1);
            if (tick_s) begin
                idx_r <= (idx_r == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Load buffer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Buffer next state: fill on accept, drain into active at the frame boundary.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY:   state_s = accept_s ? FULL : EMPTY;
            FULL:    state_s = boundary_s ? EMPTY : FULL;
            default: state_s = EMPTY;
        endcase
    end

    // Shadow captures accepted words; active takes the shadow only at a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= '0;
            active_r <= '0;
        end else begin
            shadow_r <= accept_s ? load_data : shadow_r;
            active_r <= swap_s ? shadow_r : active_r;
        end
    end

    // Digit enable for the current slot: dark on slot start, dimming, blanking or suppression.
    always_comb begin
        an_s = '1;
        if (lit_s && !blank_mask[idx_r] && (pcnt_r != '0) && !supp_s[idx_r]) begin
            an_s[idx_r] = 1'b0;
        end else begin
            an_s = '1;
        end
    end

    // Registered outputs, one cycle behind the internal counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            digit_data <= 4'h0;
            digit_idx  <= 3'd0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            an         <= an_s;
            digit_data <= active_r[idx_r*4 +: 4];
            digit_idx  <= idx_r;
            frame_done <= boundary_s;
            load_ready <= (state_s == EMPTY);
        end
    end

endmodule
